// File: rtl/lcd_pkg.sv
// Shared types and constants for the 16x2 LCD text buffer.
package lcd_pkg;

    localparam int unsigned COLS   = 16;
    localparam int unsigned CELLS  = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CELL_W = 5;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned WORD_W = 9;

    // Sequencer addresses of column 0 on each line
    localparam logic [ADDR_W-1:0] LINE1 = 6'd6;
    localparam logic [ADDR_W-1:0] LINE2 = 6'd23;

    localparam logic [CHAR_W-1:0] KEY_BS  = 8'h08;
    localparam logic [CHAR_W-1:0] KEY_CR  = 8'h0D;
    localparam logic [CHAR_W-1:0] KEY_ESC = 8'h1B;
    localparam logic [CHAR_W-1:0] BLANK   = 8'h20;

    // Word returned for addresses outside a line's window: {RS=1, space}
    localparam logic [WORD_W-1:0] OUT_OF_WINDOW = 9'h120;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    // Printable ASCII range that is stored into the text image
    function automatic logic is_printable(input logic [CHAR_W-1:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character flop array, reset to blanks, two write ports and two read ports.
module lcd_char_ram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we0,
    input  logic [CELL_W-1:0] i_wa0,
    input  logic [CHAR_W-1:0] i_wd0,
    input  logic              i_we1,
    input  logic [CELL_W-1:0] i_wa1,
    input  logic [CHAR_W-1:0] i_wd1,
    input  logic [CELL_W-1:0] i_ra0,
    output logic [CHAR_W-1:0] o_rd0,
    input  logic [CELL_W-1:0] i_ra1,
    output logic [CHAR_W-1:0] o_rd1
);

    logic [CHAR_W-1:0] r_cells [CELLS];

    // Cell storage; port 1 wins on an address collision (never used that way)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                r_cells[i] <= BLANK;
            end
        end else begin
            if (i_we0) r_cells[i_wa0] <= i_wd0;
            if (i_we1) r_cells[i_wa1] <= i_wd1;
        end
    end

    assign o_rd0 = r_cells[i_ra0];
    assign o_rd1 = r_cells[i_ra1];

endmodule

// File: rtl/lcd_text_buffer.sv
// Keyboard-side editor for the 16x2 LCD text image with sequencer read-out.
module lcd_text_buffer
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [CHAR_W-1:0] key_code,
    output logic              key_ready,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] data_mem_1,
    output logic [WORD_W-1:0] data_mem_2,
    output logic [CELL_W-1:0] cursor_pos
);

    state_t            r_state;
    logic [CELL_W-1:0] r_cursor;
    logic [CELL_W-1:0] r_index;
    logic              r_key_ready;

    logic              w_accept;
    logic              w_in1;
    logic              w_in2;
    logic [CELL_W-1:0] w_ra0;
    logic [CELL_W-1:0] w_ra1;
    logic [CHAR_W-1:0] w_rd0;
    logic [CHAR_W-1:0] w_rd1;
    logic              w_we0;
    logic [CELL_W-1:0] w_wa0;
    logic [CHAR_W-1:0] w_wd0;
    logic              w_we1;
    logic [CELL_W-1:0] w_wa1;
    logic [CHAR_W-1:0] w_wd1;

    assign w_accept = key_valid && r_key_ready;

    // The two line windows are disjoint, so one read port serves both lines
    // and the second port is free to fetch the line-2 source cell while scrolling.
    assign w_in1 = (address >= LINE1) && (address <= 6'(LINE1 + 6'd15));
    assign w_in2 = (address >= LINE2) && (address <= 6'(LINE2 + 6'd15));

    // Sequencer-side cell index; out-of-window addresses park on cell 0
    always_comb begin
        w_ra0 = '0;
        if (w_in1) begin
            w_ra0 = 5'(address - LINE1);
        end else if (w_in2) begin
            w_ra0 = 5'(6'(address - LINE2) + 6'(COLS));
        end
    end

    assign w_ra1 = {1'b1, r_index[3:0]};

    // Write-port steering for typing, backspace, scroll pairs and clear
    always_comb begin
        w_we0 = 1'b0;
        w_wa0 = r_cursor;
        w_wd0 = key_code;
        w_we1 = 1'b0;
        w_wa1 = {1'b1, r_index[3:0]};
        w_wd1 = BLANK;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_printable(key_code)) begin
                        w_we0 = 1'b1;
                    end else if ((key_code == KEY_BS) && (r_cursor != '0)) begin
                        w_we0 = 1'b1;
                        w_wa0 = r_cursor - 5'd1;
                        w_wd0 = BLANK;
                    end
                end
            end
            SCROLL: begin
                w_we0 = 1'b1;
                w_wa0 = {1'b0, r_index[3:0]};
                w_wd0 = w_rd1;
                w_we1 = 1'b1;
            end
            CLEAR: begin
                w_we0 = 1'b1;
                w_wa0 = r_index;
                w_wd0 = BLANK;
            end
            default: ;
        endcase
    end

    lcd_char_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .i_we0 (w_we0),
        .i_wa0 (w_wa0),
        .i_wd0 (w_wd0),
        .i_we1 (w_we1),
        .i_wa1 (w_wa1),
        .i_wd1 (w_wd1),
        .i_ra0 (w_ra0),
        .o_rd0 (w_rd0),
        .i_ra1 (w_ra1),
        .o_rd1 (w_rd1)
    );

    // Edit FSM: cursor, scroll/clear sweep index and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cursor    <= '0;
            r_index     <= '0;
            r_key_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_key_ready <= 1'b1;
                    if (w_accept) begin
                        if (is_printable(key_code)) begin
                            if (r_cursor == 5'd31) begin
                                r_state     <= SCROLL;
                                r_key_ready <= 1'b0;
                            end else begin
                                r_cursor <= r_cursor + 5'd1;
                            end
                        end else if (key_code == KEY_BS) begin
                            if (r_cursor != '0) r_cursor <= r_cursor - 5'd1;
                        end else if (key_code == KEY_CR) begin
                            if (r_cursor < 5'(COLS)) begin
                                r_cursor <= 5'(COLS);
                            end else begin
                                r_state     <= SCROLL;
                                r_key_ready <= 1'b0;
                            end
                        end else if (key_code == KEY_ESC) begin
                            r_state     <= CLEAR;
                            r_key_ready <= 1'b0;
                        end
                    end
                end
                SCROLL: begin
                    if (r_index == 5'd15) begin
                        r_index     <= '0;
                        r_cursor    <= 5'(COLS);
                        r_state     <= IDLE;
                        r_key_ready <= 1'b1;
                    end else begin
                        r_index <= r_index + 5'd1;
                    end
                end
                CLEAR: begin
                    if (r_index == 5'd31) begin
                        r_index     <= '0;
                        r_cursor    <= '0;
                        r_state     <= IDLE;
                        r_key_ready <= 1'b1;
                    end else begin
                        r_index <= r_index + 5'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_key_ready <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready  = r_key_ready;
    assign cursor_pos = r_cursor;
    assign data_mem_1 = w_in1 ? {1'b1, w_rd0} : OUT_OF_WINDOW;
    assign data_mem_2 = w_in2 ? {1'b1, w_rd0} : OUT_OF_WINDOW;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed self-checking bench for lcd_text_buffer.
module tb_lcd_text_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic [5:0] address;
    logic [8:0] data_mem_1;
    logic [8:0] data_mem_2;
    logic [4:0] cursor_pos;

    int errors = 0;
    int checks = 0;

    lcd_text_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .address    (address),
        .data_mem_1 (data_mem_1),
        .data_mem_2 (data_mem_2),
        .cursor_pos (cursor_pos)
    );

    always #5 clk = ~clk;

    // Present one code for a single accepting edge, waiting (bounded) for ready
    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!key_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout code=%h key_ready=%b expected 1", c, key_ready);
        end
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; address = 6'd0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", key_ready); end
        checks++;
        if (cursor_pos !== 5'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor_pos); end
        address = 6'd6; #1;
        checks++;
        if (data_mem_1 !== 9'h120) begin errors++; $display("FAIL reset_line1 got=%h exp=120", data_mem_1); end
        address = 6'd23; #1;
        checks++;
        if (data_mem_2 !== 9'h120) begin errors++; $display("FAIL reset_line2 got=%h exp=120", data_mem_2); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", key_ready); end
    endtask

    task automatic test_write();
        send(8'h48);
        send(8'h49);
        address = 6'd6; #1;
        checks++;
        if (data_mem_1 !== 9'h148) begin errors++; $display("FAIL write_cell0 got=%h exp=148", data_mem_1); end
        address = 6'd7; #1;
        checks++;
        if (data_mem_1 !== 9'h149) begin errors++; $display("FAIL write_cell1 got=%h exp=149", data_mem_1); end
        checks++;
        if (cursor_pos !== 5'd2) begin errors++; $display("FAIL write_cursor got=%0d exp=2", cursor_pos); end
    endtask

    task automatic test_backspace();
        send(8'h08);
        address = 6'd7; #1;
        checks++;
        if (data_mem_1 !== 9'h120) begin errors++; $display("FAIL bs_cell1 got=%h exp=120", data_mem_1); end
        checks++;
        if (cursor_pos !== 5'd1) begin errors++; $display("FAIL bs_cursor1 got=%0d exp=1", cursor_pos); end
        address = 6'd6; #1;
        checks++;
        if (data_mem_1 !== 9'h148) begin errors++; $display("FAIL bs_cell0_kept got=%h exp=148", data_mem_1); end
        for (int k = 0; k < 3; k++) send(8'h08);
        #1;
        checks++;
        if (data_mem_1 !== 9'h120) begin errors++; $display("FAIL bs_cell0 got=%h exp=120", data_mem_1); end
        checks++;
        if (cursor_pos !== 5'd0) begin errors++; $display("FAIL bs_underflow got=%0d exp=0", cursor_pos); end
    endtask

    task automatic test_scroll_full();
        int n = 0;
        for (int k = 0; k < 32; k++) send(8'(8'h41 + k));
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL scroll_ready_drop got=%b exp=0", key_ready); end
        while (!key_ready && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL scroll_busy_cycles got=%0d exp=16", n); end
        checks++;
        if (cursor_pos !== 5'd16) begin errors++; $display("FAIL scroll_cursor got=%0d exp=16", cursor_pos); end
        for (int a = 0; a < 16; a++) begin
            address = 6'(6 + a); #1;
            checks++;
            if (data_mem_1 !== 9'(9'h151 + a)) begin
                errors++; $display("FAIL scroll_line1[%0d] got=%h exp=%h", a, data_mem_1, 9'(9'h151 + a));
            end
            address = 6'(23 + a); #1;
            checks++;
            if (data_mem_2 !== 9'h120) begin
                errors++; $display("FAIL scroll_line2[%0d] got=%h exp=120", a, data_mem_2);
            end
        end
    endtask

    task automatic test_enter_scroll();
        int n = 0;
        send(8'h0D);
        while (!key_ready && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL enter_busy_cycles got=%0d exp=16", n); end
        checks++;
        if (cursor_pos !== 5'd16) begin errors++; $display("FAIL enter_cursor got=%0d exp=16", cursor_pos); end
        address = 6'd6; #1;
        checks++;
        if (data_mem_1 !== 9'h120) begin errors++; $display("FAIL enter_line1_first got=%h exp=120", data_mem_1); end
        address = 6'd21; #1;
        checks++;
        if (data_mem_1 !== 9'h120) begin errors++; $display("FAIL enter_line1_last got=%h exp=120", data_mem_1); end
    endtask

    task automatic test_clear();
        int n = 0;
        logic [4:0] mid_cur = '0;
        send(8'h77); send(8'h78); send(8'h79); send(8'h7A);
        address = 6'd23; #1;
        checks++;
        if (data_mem_2 !== 9'h177) begin errors++; $display("FAIL clear_pre_line2 got=%h exp=177", data_mem_2); end
        checks++;
        if (cursor_pos !== 5'd20) begin errors++; $display("FAIL clear_pre_cursor got=%0d exp=20", cursor_pos); end
        key_valid = 1'b1; key_code = 8'h1B;
        @(posedge clk); #1;
        key_code = 8'h51;
        while (!key_ready && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 10) mid_cur = cursor_pos;
        end
        checks++;
        if (n !== 32) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=32", n); end
        checks++;
        if (mid_cur !== 5'd20) begin errors++; $display("FAIL clear_held_not_taken got=%0d exp=20", mid_cur); end
        checks++;
        if (cursor_pos !== 5'd0) begin errors++; $display("FAIL clear_cursor got=%0d exp=0", cursor_pos); end
        @(posedge clk); #1;
        key_valid = 1'b0;
        checks++;
        if (cursor_pos !== 5'd1) begin errors++; $display("FAIL clear_held_taken got=%0d exp=1", cursor_pos); end
        for (int a = 0; a < 64; a++) begin
            address = 6'(a); #1;
            checks++;
            if (data_mem_1 !== ((a == 6) ? 9'h151 : 9'h120)) begin
                errors++; $display("FAIL clear_line1 addr=%0d got=%h", a, data_mem_1);
            end
            checks++;
            if (data_mem_2 !== 9'h120) begin
                errors++; $display("FAIL clear_line2 addr=%0d got=%h exp=120", a, data_mem_2);
            end
        end
    endtask

    task automatic test_enter_other();
        send(8'h0D);
        checks++;
        if (cursor_pos !== 5'd16) begin errors++; $display("FAIL enter_short got=%0d exp=16", cursor_pos); end
        send(8'h01);
        checks++;
        if (cursor_pos !== 5'd16) begin errors++; $display("FAIL other_code got=%0d exp=16", cursor_pos); end
        send(8'h45);
        address = 6'd23; #1;
        checks++;
        if (data_mem_2 !== 9'h145) begin errors++; $display("FAIL line2_write got=%h exp=145", data_mem_2); end
        checks++;
        if (cursor_pos !== 5'd17) begin errors++; $display("FAIL line2_cursor got=%0d exp=17", cursor_pos); end
    endtask

    task automatic test_reset_mid_scroll();
        send(8'h0D);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0; #1;
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", key_ready); end
        checks++;
        if (cursor_pos !== 5'd0) begin errors++; $display("FAIL midrst_cursor got=%0d exp=0", cursor_pos); end
        for (int a = 0; a < 64; a++) begin
            address = 6'(a); #1;
            checks++;
            if (data_mem_1 !== 9'h120 || data_mem_2 !== 9'h120) begin
                errors++; $display("FAIL midrst_cells addr=%0d got=%h/%h exp=120/120", a, data_mem_1, data_mem_2);
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        send(8'h5A);
        address = 6'd6; #1;
        checks++;
        if (data_mem_1 !== 9'h15A) begin errors++; $display("FAIL midrst_resume got=%h exp=15a", data_mem_1); end
        checks++;
        if (cursor_pos !== 5'd1) begin errors++; $display("FAIL midrst_resume_cursor got=%0d exp=1", cursor_pos); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_backspace();
        test_scroll_full();
        test_enter_scroll();
        test_clear();
        test_enter_other();
        test_reset_mid_scroll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Keyboard-side writer for the 16x2 character LCD sequencer.
- Holds a 32-cell text image: line 1 is cells 0-15, line 2 is cells 16-31.
- Accepts ASCII codes from the PS/2 keyboard decoder through a valid/ready handshake and applies edits: cursor advance, backspace, enter, clear, and scroll.
- Answers the sequencer's 6-bit address with 9-bit {RS, char} words on data_mem_1/data_mem_2.

Parameters:
- LINE1, 6, sequencer address of line-1 column 0
- LINE2, 23, sequencer address of line-2 column 0 (LINE1+16+1)
- COLS, 16, characters per line
- BLANK, 8'h20, fill character

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- key_valid  in  1  key_code is valid
- key_code  in  8  ASCII code from keyboard decoder
- key_ready  out  1  buffer can accept a code this cycle
- address  in  6  sequencer read address
- data_mem_1  out  9  {1'b1, line-1 char} for the current address
- data_mem_2  out  9  {1'b1, line-2 char} for the current address
- cursor_pos  out  5  next write cell, 0-31

Behaviour:
- Reset (rst=0, asynchronous):
  - all 32 cells = BLANK
  - cursor_pos = 0
  - state = IDLE, key_ready = 0 while reset is asserted
  - scroll/clear index = 0
- Accept:
  - A code is accepted on a clk edge with key_valid && key_ready.
  - key_ready = 1 only in IDLE.
  - Codes presented while busy are not accepted; the source holds key_valid.
- FSM states: IDLE, SCROLL, CLEAR.
- IDLE, accepted code:
  - 0x20-0x7E:
    - cell[cursor] <= code at the accepting edge.
    - If cursor < 31: cursor+1, stay IDLE.
    - If cursor == 31: write, then go to SCROLL.
  - 0x08 (backspace):
    - If cursor > 0: cursor-1 and cell[cursor-1] <= BLANK.
    - If cursor == 0: no-op.
  - 0x0D (enter):
    - If cursor < 16: cursor <= 16.
    - Else: go to SCROLL.
  - 0x1B (escape): go to CLEAR.
  - Any other code: accepted and discarded, no state change.
- SCROLL (16 cycles):
  - index i = 0..15, one per cycle: cell[i] <= cell[16+i] and cell[16+i] <= BLANK.
  - After i = 15: cursor <= 16, index <= 0, back to IDLE.
  - key_ready is low for exactly 16 cycles.
- CLEAR (32 cycles):
  - index i = 0..31, one per cycle: cell[i] <= BLANK.
  - Then cursor <= 0, back to IDLE.
- Read path (combinational from address and cell array):
  - data_mem_1 = {1'b1, cell[address-LINE1]} for LINE1 <= address <= LINE1+15, else 9'h120.
  - data_mem_2 = {1'b1, cell[16+address-LINE2]} for LINE2 <= address <= LINE2+15, else 9'h120.
  - A cell written at edge N is visible on the read ports after edge N. A read in the same cycle as the write returns the old value.
- Width rules:
  - Index subtraction uses 6-bit unsigned arithmetic after the range check; out-of-range addresses never index the array.
  - cursor never exceeds 31 and never wraps to 0 except through CLEAR.
- Reset mid-SCROLL or mid-CLEAR: everything returns to reset values immediately; no partial state survives.

Decomposition:
- Package lcd_pkg:
  - state enum {IDLE, SCROLL, CLEAR}
  - ASCII constants KEY_BS=8'h08, KEY_CR=8'h0D, KEY_ESC=8'h1B, BLANK=8'h20
  - address constants LINE1, LINE2, COLS, and the out-of-window value 9'h120
- One natural sub-module: lcd_char_ram, a 32x8 flop array with async reset-to-BLANK, two write ports (for the scroll pair), and two combinational read ports.

Test Plan:
- Reset, then address=6 and address=23 -> data_mem_1 = data_mem_2 = 9'h120; cursor_pos = 0; key_ready = 1 on the first cycle after release.
- Send 'H' (0x48), then 'I' (0x49) -> address=6 gives 9'h148, address=7 gives 9'h149; cursor_pos = 2.
- Send 0x08 at cursor 2, then 0x08 three more times -> cell 1 = 0x20, cursor reaches 0 and stays 0, no underflow.
- Write 32 characters 'A'..'` (0x41..0x60) -> after the 32nd, key_ready stays low for exactly 16 cycles.
  - Then address=6..21 return 9'h151..9'h160 and line 2 reads 9'h120.
  - cursor_pos = 16.
- Cursor at 20, send 0x1B with key_valid held high -> key_ready low for 32 cycles, every cell = 0x20, cursor_pos = 0. The held key is accepted only after CLEAR completes.
- Assert rst low on cycle 5 of SCROLL -> all cells = 0x20, cursor_pos = 0, state = IDLE immediately; after release, normal writes resume at cell 0.
